// File: rtl/chacha_pkg.sv
// Shared ChaCha quarter-round definitions: word type, rotation amounts,
// rotate-left helper and the four-word pipeline stage record.
package chacha_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam int unsigned ROT_L1 = 16;
   localparam int unsigned ROT_L2 = 12;
   localparam int unsigned ROT_L3 = 8;
   localparam int unsigned ROT_L4 = 7;

   // One stage of the quarter round: the four words plus the valid bit they travel with.
   typedef struct packed {
      logic  vld;
      word_t a;
      word_t b;
      word_t c;
      word_t d;
   } qr_state_t;

   function automatic word_t rotl(input word_t x, input int unsigned r);
      return (x << r) | (x >> (WORD_W - r));
   endfunction

endpackage

// File: rtl/chacha_quarter_round_if.sv
// Quarter-round port bundle. valid_i qualifies a_i..d_i, valid_o qualifies a_o..d_o;
// there is no ready: the block accepts a word set on every clock and never stalls.
interface chacha_quarter_round_if;
   import chacha_pkg::*;

   logic  valid_i;
   word_t a_i;
   word_t b_i;
   word_t c_i;
   word_t d_i;
   logic  valid_o;
   word_t a_o;
   word_t b_o;
   word_t c_o;
   word_t d_o;

   modport master (
      output valid_i, a_i, b_i, c_i, d_i,
      input  valid_o, a_o, b_o, c_o, d_o
   );

   modport slave (
      input  valid_i, a_i, b_i, c_i, d_i,
      output valid_o, a_o, b_o, c_o, d_o
   );

endinterface

// File: rtl/chacha_arx_step.sv
// One add-xor-rotate line of the quarter round: x += y; z ^= x; z <<<= R.
module chacha_arx_step
   import chacha_pkg::*;
#(
   parameter int unsigned R = ROT_L1
) (
   input  word_t x_i,
   input  word_t y_i,
   input  word_t z_i,
   output word_t x_o,
   output word_t z_o
);

   word_t sum;

   assign sum = x_i + y_i;
   assign x_o = sum;
   assign z_o = rotl(z_i ^ sum, R);

endmodule

// File: rtl/chacha_quarter_round.sv
// ChaCha20 quarter round. CHACHA_QR_PIPE_EN: register after each ARX line (latency 4);
// otherwise all four lines are combinational into one output register (latency 1).
module chacha_quarter_round
   import chacha_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   chacha_quarter_round_if.slave  qr
);

`ifdef CHACHA_QR_PIPE_EN
   localparam int NSTG = 4;
`else
   localparam int NSTG = 1;
`endif

   qr_state_t in_s;
   qr_state_t ln1_in, ln2_in, ln3_in, ln4_in;
   qr_state_t ln1_out, ln2_out, ln3_out, ln4_out;
   qr_state_t stg_d [NSTG];
   qr_state_t stg_q [NSTG];

   word_t l1_x, l1_z, l2_x, l2_z, l3_x, l3_z, l4_x, l4_z;

   assign in_s = '{vld: qr.valid_i, a: qr.a_i, b: qr.b_i, c: qr.c_i, d: qr.d_i};

   // Lines 1/3 update (a, d) from b; lines 2/4 update (c, b) from d.
   chacha_arx_step #(.R(ROT_L1)) u_line1 (
      .x_i(ln1_in.a), .y_i(ln1_in.b), .z_i(ln1_in.d), .x_o(l1_x), .z_o(l1_z)
   );
   chacha_arx_step #(.R(ROT_L2)) u_line2 (
      .x_i(ln2_in.c), .y_i(ln2_in.d), .z_i(ln2_in.b), .x_o(l2_x), .z_o(l2_z)
   );
   chacha_arx_step #(.R(ROT_L3)) u_line3 (
      .x_i(ln3_in.a), .y_i(ln3_in.b), .z_i(ln3_in.d), .x_o(l3_x), .z_o(l3_z)
   );
   chacha_arx_step #(.R(ROT_L4)) u_line4 (
      .x_i(ln4_in.c), .y_i(ln4_in.d), .z_i(ln4_in.b), .x_o(l4_x), .z_o(l4_z)
   );

   always_comb begin
      ln1_out = '{vld: ln1_in.vld, a: l1_x,     b: ln1_in.b, c: ln1_in.c, d: l1_z};
      ln2_out = '{vld: ln2_in.vld, a: ln2_in.a, b: l2_z,     c: l2_x,     d: ln2_in.d};
      ln3_out = '{vld: ln3_in.vld, a: l3_x,     b: ln3_in.b, c: ln3_in.c, d: l3_z};
      ln4_out = '{vld: ln4_in.vld, a: ln4_in.a, b: l4_z,     c: l4_x,     d: ln4_in.d};
   end

   always_comb begin
      ln1_in = in_s;
`ifdef CHACHA_QR_PIPE_EN
      ln2_in   = stg_q[0];
      ln3_in   = stg_q[1];
      ln4_in   = stg_q[2];
      stg_d[0] = ln1_out;
      stg_d[1] = ln2_out;
      stg_d[2] = ln3_out;
      stg_d[3] = ln4_out;
`else
      ln2_in   = ln1_out;
      ln3_in   = ln2_out;
      ln4_in   = ln3_out;
      stg_d[0] = ln4_out;
`endif
   end

   // Data loads every clock; only the valid bit gives it meaning downstream.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NSTG; i++) stg_q[i] <= '0;
      end else begin
         for (int i = 0; i < NSTG; i++) stg_q[i] <= stg_d[i];
      end
   end

   assign qr.valid_o = stg_q[NSTG-1].vld;
   assign qr.a_o     = stg_q[NSTG-1].a;
   assign qr.b_o     = stg_q[NSTG-1].b;
   assign qr.c_o     = stg_q[NSTG-1].c;
   assign qr.d_o     = stg_q[NSTG-1].d;

endmodule

// File: tb/tb_chacha_quarter_round.sv
// Bench for chacha_quarter_round; build with and without +define+CHACHA_QR_PIPE_EN
// (expected latency 4 and 1 respectively).
module tb_chacha_quarter_round;

`ifdef CHACHA_QR_PIPE_EN
   localparam int L = 4;
`else
   localparam int L = 1;
`endif

   localparam logic [127:0] RFC_IN   = 128'h11111111_01020304_9b8d6f43_01234567;
   localparam logic [127:0] RFC_OUT  = 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb;
   localparam logic [127:0] VEC2_IN  = 128'h516461b1_2a5f714c_53372767_3d631689;
   localparam logic [127:0] VEC2_OUT = 128'hbdb886dc_cfacafd2_e46bea80_ccc07c79;

   logic clk;
   logic rst;
   chacha_quarter_round_if io ();

   chacha_quarter_round dut (
      .clk_i(clk),
      .rst_i(rst),
      .qr   (io)
   );

   logic [127:0] dut_out;
   assign dut_out = {io.a_o, io.b_o, io.c_o, io.d_o};

   int n_vec = 0;
   int n_err = 0;

   // {valid, a, b, c, d} for each input still travelling through the block.
   logic [128:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] rol(input logic [31:0] x, input int r);
      return (x << r) | (x >> (32 - r));
   endfunction

   function automatic logic [127:0] qr_model(input logic [127:0] w);
      logic [31:0] a, b, c, d;
      {a, b, c, d} = w;
      a = a + b; d = rol(d ^ a, 16);
      c = c + d; b = rol(b ^ c, 12);
      a = a + b; d = rol(d ^ a, 8);
      c = c + d; b = rol(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // ---------------- driver ----------------
   // Drives one cycle, advances the delay-line model, returns at the next negedge
   // with what the outputs should show.
   task automatic step(input logic v, input logic [127:0] w,
                       output logic ev, output logic [127:0] ed);
      logic [128:0] e;
      io.valid_i = v;
      {io.a_i, io.b_i, io.c_i, io.d_i} = w;
      @(posedge clk);
      if (rst) exp_q.delete();
      else     exp_q.push_back({v, qr_model(w)});
      ev = 1'b0;
      ed = '0;
      if (exp_q.size() == L) begin
         e  = exp_q.pop_front();
         ev = e[128];
         ed = e[127:0];
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      io.valid_i = 1'b0;
      {io.a_i, io.b_i, io.c_i, io.d_i} = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (io.valid_o !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b want 0", io.valid_o);
      end
      n_vec++;
      if (dut_out !== 128'h0) begin
         n_err++; $display("FAIL reset_data: got %h want 0", dut_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_single(input string name, input logic [127:0] w, input logic [127:0] want);
      logic ev; logic [127:0] ed;
      int seen = 0;
      for (int i = 0; i < L + 2; i++) begin
         step(i == 0, w, ev, ed);
         n_vec++;
         if (io.valid_o !== ev) begin
            n_err++; $display("FAIL %s valid cyc %0d: got %b want %b", name, i, io.valid_o, ev);
         end else if (ev) begin
            seen++;
            n_vec++;
            if (dut_out !== want) begin
               n_err++; $display("FAIL %s data: got %h want %h", name, dut_out, want);
            end
            n_vec++;
            if (i != L - 1) begin
               n_err++; $display("FAIL %s latency: got %0d want %0d", name, i + 1, L);
            end
         end
      end
      n_vec++;
      if (seen != 1) begin
         n_err++; $display("FAIL %s pulses: got %0d want 1", name, seen);
      end
   endtask

   task automatic test_stream(input string name, input int gap);
      logic ev; logic [127:0] ed;
      logic [127:0] want [2];
      int seen = 0;
      int first_cyc = -1;
      want[0] = RFC_OUT;
      want[1] = VEC2_OUT;
      for (int i = 0; i < L + gap + 3; i++) begin
         if (i == 0)            step(1'b1, RFC_IN, ev, ed);
         else if (i == gap + 1) step(1'b1, VEC2_IN, ev, ed);
         else                   step(1'b0, 128'($urandom) << 64, ev, ed);
         n_vec++;
         if (io.valid_o !== ev) begin
            n_err++; $display("FAIL %s valid cyc %0d: got %b want %b", name, i, io.valid_o, ev);
         end else if (ev) begin
            if (seen == 0) first_cyc = i;
            n_vec++;
            if (seen > 1 || dut_out !== want[seen]) begin
               n_err++; $display("FAIL %s data #%0d: got %h want %h", name, seen, dut_out, want[seen & 1]);
            end
            n_vec++;
            if (i != first_cyc + seen * (gap + 1)) begin
               n_err++; $display("FAIL %s spacing #%0d: got cyc %0d want %0d", name, seen, i,
                                 first_cyc + seen * (gap + 1));
            end
            seen++;
         end
      end
      n_vec++;
      if (seen != 2) begin
         n_err++; $display("FAIL %s pulses: got %0d want 2", name, seen);
      end
   endtask

   task automatic test_reset_mid();
      logic ev; logic [127:0] ed;
      step(1'b1, VEC2_IN, ev, ed);
      n_vec++;
      if (io.valid_o !== ev) begin
         n_err++; $display("FAIL midrst_pre valid: got %b want %b", io.valid_o, ev);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (io.valid_o !== 1'b0) begin
         n_err++; $display("FAIL midrst_async valid: got %b want 0", io.valid_o);
      end
      n_vec++;
      if (dut_out !== 128'h0) begin
         n_err++; $display("FAIL midrst_async data: got %h want 0", dut_out);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         step(1'b1, {$urandom, $urandom, $urandom, $urandom}, ev, ed);
         n_vec++;
         if (io.valid_o !== 1'b0 || dut_out !== 128'h0) begin
            n_err++; $display("FAIL midrst_hold: got %b/%h want 0/0", io.valid_o, dut_out);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < L + 2; i++) begin
         step(1'b0, 128'h0, ev, ed);
         n_vec++;
         if (io.valid_o !== 1'b0) begin
            n_err++; $display("FAIL midrst_stale cyc %0d: got %b want 0", i, io.valid_o);
         end
      end
      test_single("midrst_rfc", RFC_IN, RFC_OUT);
   endtask

   task automatic test_random(input int cycles);
      logic ev; logic [127:0] ed;
      for (int i = 0; i < cycles + L; i++) begin
         step(i < cycles ? 1'($urandom_range(0, 1)) : 1'b0,
              {$urandom, $urandom, $urandom, $urandom}, ev, ed);
         n_vec++;
         if (io.valid_o !== ev) begin
            n_err++; $display("FAIL random valid cyc %0d: got %b want %b", i, io.valid_o, ev);
         end else if (ev) begin
            n_vec++;
            if (dut_out !== ed) begin
               n_err++; $display("FAIL random data cyc %0d: got %h want %h", i, dut_out, ed);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single("rfc7539", RFC_IN, RFC_OUT);
      test_single("vector2", VEC2_IN, VEC2_OUT);
      test_single("zero", 128'h0, 128'h0);
      test_stream("back_to_back", 0);
      test_stream("bubble", 1);
      test_reset_mid();
      test_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
